pwm_meter: RTL and testbench

//  Downstream consumer of the PWM generator output. Synchronises the PWM line,

---
 rtl/pwm_meter_pkg.sv | 17 +
 rtl/pwm_sync_edge.sv | 32 +++
 rtl/pwm_meter.sv | 129 ++++++++++++
 tb/tb_pwm_meter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_meter_pkg.sv
// Shared definitions for the PWM generator/meter pair: FSM encoding and record layout.
// A record is packed MSB-first as {stuck, level, high, period}.
package pwm_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } meter_state_e;

  localparam int unsigned REC_FLAG_W = 2;

  function automatic int unsigned rec_width(input int unsigned cnt_w);
    return REC_FLAG_W + 2 * cnt_w;
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Brings the asynchronous PWM line into the clock domain and derives single-cycle
// rise/fall strobes from the synchronised level.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pwm_i,
  output logic pwm_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_d_q;

  // Synchroniser chain followed by the one-cycle delay used for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      pwm_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      pwm_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pwm_s_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~pwm_d_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & pwm_d_q;

endmodule

// File: rtl/pwm_meter.sv
// Measures high time and period of a PWM line and hands each completed record
// to a valid/ready consumer; a line without edges for 2**CNT_W-1 cycles yields a stuck record.
module pwm_meter
  import pwm_meter_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_stuck,
  output logic             meas_level,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun
);

  localparam int REC_W = int'(rec_width(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic pwm_s, rise, fall;

  pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock   (clock),
    .reset   (reset),
    .pwm_i   (pwm_in),
    .pwm_s_o (pwm_s),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d, per_q, per_d;
  logic             pub_q, pub_d;
  logic [REC_W-1:0] pub_rec_q, pub_rec_d;
  logic [REC_W-1:0] out_rec_q;
  logic             valid_q, overrun_q;

  // Measurement FSM: a rise closes the running period and immediately opens the next.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    per_d     = per_q;
    pub_d     = 1'b0;
    pub_rec_d = pub_rec_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          hi_d    = CNT_ONE;
          per_d   = CNT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH, ST_LOW: begin
        if (rise) begin
          pub_d     = 1'b1;
          pub_rec_d = {1'b0, 1'b0, hi_q, per_q};
          state_d   = ST_HIGH;
          hi_d      = CNT_ONE;
          per_d     = CNT_ONE;
        end else if (per_q == CNT_MAX) begin
          pub_d     = 1'b1;
          pub_rec_d = {1'b1, pwm_s, (pwm_s ? CNT_MAX : hi_q), CNT_MAX};
          state_d   = ST_IDLE;
        end else begin
          per_d = per_q + CNT_ONE;
          if (state_q == ST_HIGH && !fall) begin
            hi_d    = (hi_q == CNT_MAX) ? hi_q : hi_q + CNT_ONE;
            state_d = ST_HIGH;
          end else begin
            state_d = ST_LOW;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, counters and the one-cycle publish stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      per_q     <= '0;
      pub_q     <= 1'b0;
      pub_rec_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      per_q     <= per_d;
      pub_q     <= pub_d;
      pub_rec_q <= pub_rec_d;
    end
  end

  // Output record with handshake; a record arriving while one is stalled is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_rec_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (pub_q) begin
      if (valid_q && !meas_ready) begin
        overrun_q <= 1'b1;
      end else begin
        out_rec_q <= pub_rec_q;
        valid_q   <= 1'b1;
      end
    end else if (valid_q && meas_ready) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign meas_stuck  = out_rec_q[REC_W-1];
  assign meas_level  = out_rec_q[REC_W-2];
  assign meas_high   = out_rec_q[2*CNT_W-1:CNT_W];
  assign meas_period = out_rec_q[CNT_W-1:0];
  assign meas_valid  = valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pwm_meter.sv
// Directed bench for pwm_meter (CNT_W=8, SYNC_STAGES=2): records are captured on
// each accepted handshake and compared against hand-computed values.
module tb_pwm_meter;

  logic       clock = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic       meas_ready;
  logic [7:0] meas_high, meas_period;
  logic       meas_stuck, meas_level, meas_valid, overrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [17:0] rec_q[$];
  int          cyc_q[$];

  pwm_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .meas_high   (meas_high),
    .meas_period (meas_period),
    .meas_stuck  (meas_stuck),
    .meas_level  (meas_level),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Capture every accepted record together with the cycle it was accepted in.
  always @(negedge clock) begin
    if (!reset && meas_valid && meas_ready) begin
      rec_q.push_back({meas_stuck, meas_level, meas_high, meas_period});
      cyc_q.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pwm_cycle(input int hi, input int per);
    pwm_in = 1'b1;
    tick(hi);
    pwm_in = 1'b0;
    tick(per - hi);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pwm_in = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    rec_q.delete();
    cyc_q.delete();
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    pwm_in     = 1'b0;
    meas_ready = 1'b0;
    tick(3);
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", meas_valid); end
    checks++; if (meas_high !== 8'd0) begin errors++; $display("FAIL reset_high got=%0d exp=0", meas_high); end
    checks++; if (meas_period !== 8'd0) begin errors++; $display("FAIL reset_period got=%0d exp=0", meas_period); end
    checks++; if (meas_stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck got=%b exp=0", meas_stuck); end
    checks++; if (meas_level !== 1'b0) begin errors++; $display("FAIL reset_level got=%b exp=0", meas_level); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    reset = 1'b0;
    tick(40);
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL const_line_valid got=%b exp=0", meas_valid); end
  endtask

  task automatic test_latency();
    int edge_cyc;
    int lat;
    do_reset();
    meas_ready = 1'b0;
    pwm_cycle(2, 20);
    pwm_in   = 1'b1;
    edge_cyc = cyc;
    lat      = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (meas_valid) begin
        lat = cyc - edge_cyc;
        break;
      end
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL latency got=%0d exp=4", lat); end
    checks++;
    if ({meas_stuck, meas_level, meas_high, meas_period} !== {1'b0, 1'b0, 8'd2, 8'd20}) begin
      errors++; $display("FAIL latency_rec got=%b/%b/%0d/%0d exp=0/0/2/20", meas_stuck, meas_level, meas_high, meas_period);
    end
    tick(2);
  endtask

  task automatic test_periodic();
    logic [17:0] exp_rec;
    exp_rec = {1'b0, 1'b0, 8'd2, 8'd20};
    do_reset();
    meas_ready = 1'b1;
    repeat (4) pwm_cycle(2, 20);
    pwm_in = 1'b1;
    tick(8);
    checks++; if (rec_q.size() != 4) begin errors++; $display("FAIL periodic_count got=%0d exp=4", rec_q.size()); end
    if (rec_q.size() >= 4) begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (rec_q[i] !== exp_rec) begin errors++; $display("FAIL periodic_rec%0d got=%h exp=%h", i, rec_q[i], exp_rec); end
      end
      checks++;
      if (cyc_q[2] - cyc_q[1] != 20) begin errors++; $display("FAIL periodic_spacing got=%0d exp=20", cyc_q[2] - cyc_q[1]); end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL periodic_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_duty_sweep();
    logic [7:0] exp_hi [3];
    exp_hi = '{8'd1, 8'd10, 8'd19};
    do_reset();
    meas_ready = 1'b1;
    pwm_cycle(5, 20);
    pwm_cycle(1, 20);
    pwm_cycle(10, 20);
    pwm_cycle(19, 20);
    pwm_in = 1'b1;
    tick(8);
    checks++; if (rec_q.size() != 4) begin errors++; $display("FAIL duty_count got=%0d exp=4", rec_q.size()); end
    if (rec_q.size() >= 4) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rec_q[i+1] !== {1'b0, 1'b0, exp_hi[i], 8'd20}) begin
          errors++; $display("FAIL duty_%0d got=%h exp=%h", exp_hi[i], rec_q[i+1], {1'b0, 1'b0, exp_hi[i], 8'd20});
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] held;
    do_reset();
    meas_ready = 1'b0;
    pwm_cycle(3, 20);
    pwm_cycle(9, 20);
    tick(0);
    held = {meas_stuck, meas_level, meas_high, meas_period};
    checks++; if (meas_valid !== 1'b1 || held !== {1'b0, 1'b0, 8'd3, 8'd20}) begin
      errors++; $display("FAIL bp_first valid=%b got=%h exp=%h", meas_valid, held, {1'b0, 1'b0, 8'd3, 8'd20});
    end
    pwm_in = 1'b1;
    tick(5);
    pwm_in = 1'b0;
    tick(5);
    checks++; if ({meas_stuck, meas_level, meas_high, meas_period} !== {1'b0, 1'b0, 8'd3, 8'd20}) begin
      errors++; $display("FAIL bp_stable got=%h exp=%h", {meas_stuck, meas_level, meas_high, meas_period}, {1'b0, 1'b0, 8'd3, 8'd20});
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got=%b exp=1", overrun); end
    meas_ready = 1'b1;
    tick(10);
    pwm_in = 1'b1;
    tick(8);
    checks++; if (rec_q.size() != 2) begin errors++; $display("FAIL bp_count got=%0d exp=2", rec_q.size()); end
    if (rec_q.size() >= 2) begin
      checks++; if (rec_q[0] !== {1'b0, 1'b0, 8'd3, 8'd20}) begin errors++; $display("FAIL bp_held_first got=%h exp=%h", rec_q[0], {1'b0, 1'b0, 8'd3, 8'd20}); end
      checks++; if (rec_q[1] !== {1'b0, 1'b0, 8'd5, 8'd20}) begin errors++; $display("FAIL bp_next got=%h exp=%h", rec_q[1], {1'b0, 1'b0, 8'd5, 8'd20}); end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_stuck();
    do_reset();
    meas_ready = 1'b1;
    pwm_in = 1'b1;
    tick(275);
    checks++; if (rec_q.size() != 1) begin errors++; $display("FAIL stuck_hi_count got=%0d exp=1", rec_q.size()); end
    if (rec_q.size() >= 1) begin
      checks++; if (rec_q[0] !== {1'b1, 1'b1, 8'd255, 8'd255}) begin errors++; $display("FAIL stuck_hi got=%h exp=%h", rec_q[0], {1'b1, 1'b1, 8'd255, 8'd255}); end
    end
    do_reset();
    meas_ready = 1'b1;
    pwm_in = 1'b1;
    tick(6);
    pwm_in = 1'b0;
    tick(275);
    checks++; if (rec_q.size() != 1) begin errors++; $display("FAIL stuck_lo_count got=%0d exp=1", rec_q.size()); end
    if (rec_q.size() >= 1) begin
      checks++; if (rec_q[0] !== {1'b1, 1'b0, 8'd6, 8'd255}) begin errors++; $display("FAIL stuck_lo got=%h exp=%h", rec_q[0], {1'b1, 1'b0, 8'd6, 8'd255}); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    meas_ready = 1'b1;
    pwm_in = 1'b1;
    tick(300);
    pwm_in = 1'b0;
    tick(10);
    pwm_cycle(4, 20);
    pwm_in = 1'b1;
    tick(8);
    checks++; if (rec_q.size() != 2) begin errors++; $display("FAIL sat_count got=%0d exp=2", rec_q.size()); end
    if (rec_q.size() >= 2) begin
      checks++; if (rec_q[0] !== {1'b1, 1'b1, 8'd255, 8'd255}) begin errors++; $display("FAIL sat_stuck got=%h exp=%h", rec_q[0], {1'b1, 1'b1, 8'd255, 8'd255}); end
      checks++; if (rec_q[1] !== {1'b0, 1'b0, 8'd4, 8'd20}) begin errors++; $display("FAIL sat_resume got=%h exp=%h", rec_q[1], {1'b0, 1'b0, 8'd4, 8'd20}); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    meas_ready = 1'b0;
    pwm_cycle(3, 20);
    pwm_in = 1'b1;
    tick(6);
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_valid got=%b exp=1", meas_valid); end
    reset  = 1'b1;
    pwm_in = 1'b0;
    #2;
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", meas_valid); end
    checks++; if ({meas_stuck, meas_level, meas_high, meas_period, overrun} !== 19'd0) begin
      errors++; $display("FAIL rst_mid_outputs got=%h exp=0", {meas_stuck, meas_level, meas_high, meas_period, overrun});
    end
    tick(2);
    reset = 1'b0;
    tick(1);
    rec_q.delete();
    cyc_q.delete();
    meas_ready = 1'b1;
    pwm_cycle(4, 20);
    checks++; if (rec_q.size() != 0) begin errors++; $display("FAIL rst_mid_early got=%0d exp=0", rec_q.size()); end
    pwm_in = 1'b1;
    tick(8);
    checks++; if (rec_q.size() != 1) begin errors++; $display("FAIL rst_mid_count got=%0d exp=1", rec_q.size()); end
    if (rec_q.size() >= 1) begin
      checks++; if (rec_q[0] !== {1'b0, 1'b0, 8'd4, 8'd20}) begin errors++; $display("FAIL rst_mid_rec got=%h exp=%h", rec_q[0], {1'b0, 1'b0, 8'd4, 8'd20}); end
    end
  endtask

  initial begin
    reset      = 1'b1;
    pwm_in     = 1'b0;
    meas_ready = 1'b0;
    test_reset();
    test_latency();
    test_periodic();
    test_duty_sweep();
    test_backpressure();
    test_stuck();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
